// File: rtl/debounce_pkg.sv
// debounce_pkg
//   Shared types and default constants for the debounce_edge input conditioner.
//   - db_state_t      : qualification FSM states
//   - DEF_SYNC_STAGES : default synchroniser depth
//   - DEF_DEBOUNCE    : default number of identical samples needed to accept a change
//   - DEF_EVT_W       : default width of the accepted-transition counter
package debounce_pkg;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_RISE_CHK = 2'd1,
    ST_HIGH     = 2'd2,
    ST_FALL_CHK = 2'd3
  } db_state_t;

  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE    = 4;
  localparam int DEF_EVT_W       = 8;

  // Width needed to hold a qualification count of 0..n.
  function automatic int qual_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/debounce_edge_sync_ff.sv
// sync_ff
//   Multi-flop synchroniser for a single asynchronous bit. The input is
//   shifted through STAGES flops; only the last flop is visible downstream.
//   Ports:
//     clk   in  1  clock
//     reset in  1  synchronous active-high reset, clears every stage to 0
//     d_i   in  1  asynchronous input
//     q_o   out 1  synchronised output (last stage)
module sync_ff
  import debounce_pkg::*;
#(
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sr_q;
  logic [STAGES-1:0] sr_d;

  // Stage 0 takes the raw input, each later stage takes its predecessor.
  always_comb begin
    sr_d = {sr_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign q_o = sr_q[STAGES-1];

endmodule

// File: rtl/debounce_edge.sv
// debounce_edge
//   Conditions a raw, bouncy, asynchronous 1-bit input. The input is
//   synchronised, and a level change is accepted only after DEBOUNCE_CYCLES
//   consecutive identical synchronised samples. Produces a clean level,
//   single-cycle rise/fall pulses and a wrapping accepted-transition count.
//   Every output comes straight from a flop.
//   Ports:
//     clk       in  1      clock, all state on posedge
//     reset     in  1      synchronous active-high reset
//     d_i       in  1      raw asynchronous input
//     stable_o  out 1      debounced level
//     rise_o    out 1      one-cycle pulse on accepted 0->1
//     fall_o    out 1      one-cycle pulse on accepted 1->0
//     evt_cnt_o out EVT_W  accepted transitions, wraps modulo 2^EVT_W
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int EVT_W           = DEF_EVT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             d_i,
  output logic             stable_o,
  output logic             rise_o,
  output logic             fall_o,
  output logic [EVT_W-1:0] evt_cnt_o
);

  localparam int QW = qual_width(DEBOUNCE_CYCLES);
  localparam logic [QW-1:0]    QUAL_ONE  = QW'(1);
  localparam logic [QW-1:0]    QUAL_LAST = QW'(DEBOUNCE_CYCLES - 1);
  localparam logic [EVT_W-1:0] CNT_ONE   = EVT_W'(1);

  // ---------------------------------------------------------------------
  // Synchroniser: nothing past this point looks at d_i.
  // ---------------------------------------------------------------------
  logic d_sync;

  sync_ff #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (d_i),
    .q_o   (d_sync)
  );

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  db_state_t        state_q,  state_d;
  logic [QW-1:0]    qual_q,   qual_d;
  logic             stable_q, stable_d;
  logic             rise_q,   rise_d;
  logic             fall_q,   fall_d;
  logic [EVT_W-1:0] cnt_q,    cnt_d;

  // Qualification completes on the DEBOUNCE_CYCLES-th consecutive sample:
  // the entry sample counts as 1, so the final one arrives at count N-1.
  logic qual_done;
  assign qual_done = (qual_q == QUAL_LAST);

  logic accept_rise;
  logic accept_fall;
  assign accept_rise = (state_q == ST_RISE_CHK) &&  d_sync && qual_done;
  assign accept_fall = (state_q == ST_FALL_CHK) && !d_sync && qual_done;

  // ---------------------------------------------------------------------
  // Process 1: state register
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOW;
      qual_q  <= '0;
    end else begin
      state_q <= state_d;
      qual_q  <= qual_d;
    end
  end

  // ---------------------------------------------------------------------
  // Process 2: next-state logic
  // Any opposite sample inside a *_CHK state drops straight back to the
  // settled state with the count cleared, so no partial credit survives.
  // ---------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    qual_d  = qual_q;
    unique case (state_q)
      ST_LOW: begin
        if (d_sync) begin
          state_d = ST_RISE_CHK;
          qual_d  = QUAL_ONE;
        end
      end
      ST_RISE_CHK: begin
        if (!d_sync) begin
          state_d = ST_LOW;
          qual_d  = '0;
        end else if (qual_done) begin
          state_d = ST_HIGH;
          qual_d  = '0;
        end else begin
          qual_d  = qual_q + QUAL_ONE;
        end
      end
      ST_HIGH: begin
        if (!d_sync) begin
          state_d = ST_FALL_CHK;
          qual_d  = QUAL_ONE;
        end
      end
      ST_FALL_CHK: begin
        if (d_sync) begin
          state_d = ST_HIGH;
          qual_d  = '0;
        end else if (qual_done) begin
          state_d = ST_LOW;
          qual_d  = '0;
        end else begin
          qual_d  = qual_q + QUAL_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        qual_d  = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Process 3: output logic (registered below)
  // Pulses are one cycle because they default low every cycle and are
  // only raised on the single acceptance cycle.
  // ---------------------------------------------------------------------
  always_comb begin
    stable_d = stable_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    cnt_d    = cnt_q;
    if (accept_rise) begin
      stable_d = 1'b1;
      rise_d   = 1'b1;
      cnt_d    = cnt_q + CNT_ONE;
    end else if (accept_fall) begin
      stable_d = 1'b0;
      fall_d   = 1'b1;
      cnt_d    = cnt_q + CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stable_q <= 1'b0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      cnt_q    <= cnt_d;
    end
  end

  assign stable_o  = stable_q;
  assign rise_o    = rise_q;
  assign fall_o    = fall_q;
  assign evt_cnt_o = cnt_q;

endmodule

// File: tb/tb_debounce_edge.sv
// tb_debounce_edge
//   Bench for debounce_edge. Two instances share stimulus: default widths
//   and EVT_W=2 (counter wrap). A behavioural run-length model predicts the
//   outputs at every edge; predictions are queued and compared on the
//   following negedge. Directed checks cover latency and the wrap sequence.
module tb_debounce_edge;

  localparam int SYNC = 2;
  localparam int DC   = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       d_i;
  logic       stable_o, rise_o, fall_o;
  logic [7:0] evt_cnt_o;
  logic       stable2_o, rise2_o, fall2_o;
  logic [1:0] evt_cnt2_o;

  always #5 clk = ~clk;

  debounce_edge #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .EVT_W(8)) u_dut (
    .clk(clk), .reset(reset), .d_i(d_i),
    .stable_o(stable_o), .rise_o(rise_o), .fall_o(fall_o), .evt_cnt_o(evt_cnt_o)
  );

  debounce_edge #(.SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DC), .EVT_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .d_i(d_i),
    .stable_o(stable2_o), .rise_o(rise2_o), .fall_o(fall2_o), .evt_cnt_o(evt_cnt2_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------
  // Reference model: counts consecutive synchronised samples that differ
  // from the current debounced level; the DC-th such sample flips it.
  // ---------------------------------------------------------------------
  typedef struct {
    logic       stable;
    logic       rise;
    logic       fall;
    logic [7:0] cnt8;
    logic [1:0] cnt2;
  } exp_t;

  exp_t           sb_q[$];
  logic [SYNC-1:0] m_sync;
  logic            m_stable, m_rise, m_fall;
  int              m_run;
  int              m_cnt;

  always @(posedge clk) begin
    logic ds;
    exp_t e;
    if (reset) begin
      m_sync = '0; m_stable = 1'b0; m_rise = 1'b0; m_fall = 1'b0;
      m_run = 0; m_cnt = 0;
    end else begin
      ds = m_sync[SYNC-1];
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (ds != m_stable) begin
        m_run++;
        if (m_run == DC) begin
          m_stable = ds;
          m_rise   = ds;
          m_fall   = !ds;
          m_cnt++;
          m_run    = 0;
        end
      end else begin
        m_run = 0;
      end
      m_sync = {m_sync[SYNC-2:0], d_i};
    end
    e.stable = m_stable;
    e.rise   = m_rise;
    e.fall   = m_fall;
    e.cnt8   = 8'(m_cnt);
    e.cnt2   = 2'(m_cnt);
    sb_q.push_back(e);
  end

  always @(negedge clk) begin
    exp_t e;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("stable",  32'(stable_o),   32'(e.stable));
      chk("rise",    32'(rise_o),     32'(e.rise));
      chk("fall",    32'(fall_o),     32'(e.fall));
      chk("cnt8",    32'(evt_cnt_o),  32'(e.cnt8));
      chk("stable2", 32'(stable2_o),  32'(e.stable));
      chk("cnt2",    32'(evt_cnt2_o), 32'(e.cnt2));
      chk("pulse_excl", 32'(rise_o & fall_o), 32'd0);
    end
  end

  // Wait (bounded) for the next rise/fall pulse; returns edges waited,
  // 0 on timeout. Returns 1 time unit after the edge that shows it.
  task automatic wait_pulse(output int edges);
    edges = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (rise_o || fall_o) begin
        edges = i;
        return;
      end
    end
    chk("pulse_timeout", 32'd0, 32'd1);
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int edges;
    logic [1:0] wrap_exp [5];
    wrap_exp[0] = 2'd1; wrap_exp[1] = 2'd2; wrap_exp[2] = 2'd3;
    wrap_exp[3] = 2'd0; wrap_exp[4] = 2'd1;

    // 1. Reset held with d_i=1; scoreboard sees all-zero outputs.
    reset = 1'b1; d_i = 1'b1;
    step(3);
    chk("rst_stable", 32'(stable_o), 32'd0);
    chk("rst_cnt",    32'(evt_cnt_o), 32'd0);

    // 2. Release with d_i=1 held: rise exactly 6 edges later.
    reset = 1'b0;
    wait_pulse(edges);
    chk("rise_latency", 32'(edges), 32'd6);
    chk("rise_seen",    32'(rise_o), 32'd1);
    chk("cnt_after_rise", 32'(evt_cnt_o), 32'd1);
    #1; step(3);

    // 4. From high, hold d_i=0: fall after 6 edges, count 2.
    d_i = 1'b0;
    wait_pulse(edges);
    chk("fall_latency", 32'(edges), 32'd6);
    chk("fall_seen",    32'(fall_o), 32'd1);
    chk("cnt_after_fall", 32'(evt_cnt_o), 32'd2);
    #1; step(3);

    // 3. From low, d_i=1 for 3 cycles then 0: rejected.
    d_i = 1'b1; step(3);
    d_i = 1'b0; step(10);
    chk("short_stable", 32'(stable_o), 32'd0);
    chk("short_cnt",    32'(evt_cnt_o), 32'd2);

    // 5. d_i=1, reset asserted for the 4th edge, then released.
    d_i = 1'b1; step(3);
    reset = 1'b1; step(1);
    chk("midrst_stable", 32'(stable_o), 32'd0);
    chk("midrst_cnt",    32'(evt_cnt_o), 32'd0);
    reset = 1'b0;
    wait_pulse(edges);
    chk("rerise_latency", 32'(edges), 32'd6);
    chk("rerise_seen",    32'(rise_o), 32'd1);
    #1; step(3);

    // 6. Fresh reset with d_i=0, then 5 accepted toggles on the 2-bit counter.
    reset = 1'b1; d_i = 1'b0; step(2);
    reset = 1'b0; step(2);
    for (int k = 0; k < 5; k++) begin
      d_i = ~d_i;
      wait_pulse(edges);
      chk("wrap_cnt2", 32'(evt_cnt2_o), 32'(wrap_exp[k]));
      #1;
    end
    step(3);

    // Bouncy random runs of 1..7 cycles, checked by the scoreboard.
    for (int k = 0; k < 60; k++) begin
      d_i = ~d_i;
      step($urandom_range(7, 1));
    end
    step(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
